// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, RGB332 field widths, test-pattern codes, counter widths
package vga_pkg;
   localparam int H_ACTIVE_640 = 640;
   localparam int H_FP_640     = 16;
   localparam int H_SYNC_640   = 96;
   localparam int H_BP_640     = 48;
   localparam int V_ACTIVE_480 = 480;
   localparam int V_FP_480     = 10;
   localparam int V_SYNC_480   = 2;
   localparam int V_BP_480     = 33;
   localparam int H_CNT_W      = 11;
   localparam int V_CNT_W      = 10;
   localparam int RED_W        = 3;
   localparam int GREEN_W      = 3;
   localparam int BLUE_W       = 2;
   typedef enum logic [1:0] {
      PAT_BARS  = 2'b00,
      PAT_CHECK = 2'b01,
      PAT_WHITE = 2'b10,
      PAT_EXT   = 2'b11
   } pat_sel_e;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis giving position, active window, sync level and wrap strobe
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int   W      = H_CNT_W,
   parameter int   ACTIVE = H_ACTIVE_640,
   parameter int   FP     = H_FP_640,
   parameter int   SYNC   = H_SYNC_640,
   parameter int   BP     = H_BP_640,
   parameter logic POL    = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         active,
   output logic         sync,
   output logic         wrap
);
   localparam int TOTAL = ACTIVE + FP + SYNC + BP;
   logic [31:0] c;
   assign c      = 32'(count);
   assign active = c < ACTIVE;
   assign sync   = (c >= ACTIVE + FP && c < ACTIVE + FP + SYNC) ? POL : ~POL;
   assign wrap   = en && c == TOTAL - 1;
   // advance on enable, returning to 0 after the last position of the axis
   always_ff @(posedge clk)
      if (!rst_n) count <= '0;
      else if (en) count <= wrap ? '0 : count + W'(1);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA timing and RGB332 output; define VGA_TEST_PATTERN_EN for built-in patterns
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   CLK_DIV  = 4,
   parameter int   H_ACTIVE = H_ACTIVE_640,
   parameter int   H_FP     = H_FP_640,
   parameter int   H_SYNC   = H_SYNC_640,
   parameter int   H_BP     = H_BP_640,
   parameter int   V_ACTIVE = V_ACTIVE_480,
   parameter int   V_FP     = V_FP_480,
   parameter int   V_SYNC   = V_SYNC_480,
   parameter int   V_BP     = V_BP_480,
   parameter logic H_POL    = 1'b0,
   parameter logic V_POL    = 1'b0
) (
   input  logic        CLK_100MHz,
   input  logic        RST_n,
   input  logic [7:0]  DPSwitch,
   input  logic [7:0]  PixelIn,
   output logic [10:0] PixelX,
   output logic [9:0]  PixelY,
   output logic        PixelReq,
   output logic        FrameStart,
   output logic        HSync,
   output logic        VSync,
   output logic [2:0]  Red,
   output logic [2:0]  Green,
   output logic [1:0]  Blue,
   output logic [7:0]  LED
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   if (CLK_DIV < 1) $error("CLK_DIV must be at least 1");
   if (H_TOTAL > 2048) $error("H_TOTAL does not fit the 11-bit horizontal counter");
   if (V_TOTAL > 1024) $error("V_TOTAL does not fit the 10-bit vertical counter");
   logic [DW-1:0] div_cnt;
   logic          pix_ce, h_act, v_act, h_sync, v_sync, h_wrap, v_wrap, run, led0;
   logic [7:0]    src, rgb, frame_cnt;
   logic          unused_bits;
   assign pix_ce = div_cnt == DW'(CLK_DIV - 1);
   // clock-enable divider: one pix_ce every CLK_DIV clocks, permanently high when CLK_DIV is 1
   always_ff @(posedge CLK_100MHz)
      div_cnt <= (!RST_n || pix_ce) ? '0 : div_cnt + DW'(1);
   vga_axis_counter #(
      .W(H_CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
   ) u_h (
      .clk(CLK_100MHz), .rst_n(RST_n), .en(pix_ce),
      .count(PixelX), .active(h_act), .sync(h_sync), .wrap(h_wrap)
   );
   vga_axis_counter #(
      .W(V_CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
   ) u_v (
      .clk(CLK_100MHz), .rst_n(RST_n), .en(h_wrap),
      .count(PixelY), .active(v_act), .sync(v_sync), .wrap(v_wrap)
   );
`ifdef VGA_TEST_PATTERN_EN
   logic [2:0] bar;
   assign bar = 3'(PixelX / 11'(H_ACTIVE / 8));
   assign src = DPSwitch[2:1] == PAT_BARS  ? {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}} :
                DPSwitch[2:1] == PAT_CHECK ? {8{PixelX[5] ^ PixelY[5]}} :
                DPSwitch[2:1] == PAT_WHITE ? 8'hFF : PixelIn;
`else
   assign src = PixelIn;
`endif
   assign unused_bits = ^{DPSwitch[6:1], frame_cnt[7]};
   assign PixelReq    = run && h_act && v_act;
   assign {Red, Green, Blue} = rgb;
   assign LED         = {frame_cnt[6:0], led0};
   // pixel-rate outputs: syncs and blanked RGB lag the requested coordinate by one pixel
   always_ff @(posedge CLK_100MHz)
      if (!RST_n) begin
         HSync <= ~H_POL;
         VSync <= ~V_POL;
         rgb   <= '0;
      end else if (pix_ce) begin
         HSync <= h_sync;
         VSync <= v_sync;
         rgb   <= (h_act && v_act && !DPSwitch[7]) ? src : '0;
      end
   // per-clock status: request gate, frame pulse on (0,0) entry, frame counter, switch echo
   always_ff @(posedge CLK_100MHz)
      if (!RST_n) begin
         run        <= 1'b0;
         FrameStart <= 1'b0;
         frame_cnt  <= '0;
         led0       <= 1'b0;
      end else begin
         run        <= 1'b1;
         FrameStart <= v_wrap;
         frame_cnt  <= frame_cnt + 8'(FrameStart);
         led0       <= DPSwitch[0];
      end
endmodule
